ram_access_arbiter: RTL and testbench

RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

---
 rtl/ram_access_arbiter_if.sv | 27 ++
 rtl/ram_access_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_access_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_arbiter_if.sv
// Bus bundle between two SRAM requesters, the arbiter, and the RAM I/F unit.
//   Requester A/B: iReqX, iWeX (1=write), iAdrsX, iWdX in; oAckX, oRdX, oRvdX out.
//   RAM side:      oAdrs, oWd, oCmd (1=write), oCke (beat strobe) out; iRd, iRvd in.
// slave  = arbiter view, master = requesters + RAM I/F view.
interface ram_access_arbiter_if #(
  parameter int pRamAdrsWidth = 18,
  parameter int pRamDqWidth   = 16
);
  logic                     iReqA, iWeA, oAckA, oRvdA;
  logic [pRamAdrsWidth-1:0] iAdrsA;
  logic [pRamDqWidth-1:0]   iWdA, oRdA;
  logic                     iReqB, iWeB, oAckB, oRvdB;
  logic [pRamAdrsWidth-1:0] iAdrsB;
  logic [pRamDqWidth-1:0]   iWdB, oRdB;
  logic [pRamAdrsWidth-1:0] oAdrs;
  logic [pRamDqWidth-1:0]   oWd, iRd;
  logic                     oCmd, oCke, iRvd;

  modport slave (
    input  iReqA, iWeA, iAdrsA, iWdA, iReqB, iWeB, iAdrsB, iWdB, iRd, iRvd,
    output oAckA, oRdA, oRvdA, oAckB, oRdB, oRvdB, oAdrs, oWd, oCmd, oCke
  );
  modport master (
    output iReqA, iWeA, iAdrsA, iWdA, iReqB, iWeB, iAdrsB, iWdB, iRd, iRvd,
    input  oAckA, oRdA, oRvdA, oAckB, oRdB, oRvdB, oAdrs, oWd, oCmd, oCke
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Two-requester SRAM access arbiter.
//   iCLK, iRST : clock, synchronous active-high reset
//   bus        : requester A/B handshakes and RAM I/F side (slave modport)
//   oErr       : sticky, set when read data returns with no read outstanding
// Round-robin grant with a burst cap of pBurstMax beats while the other side
// waits. Read owners are tracked in an in-order tag FIFO so returned data is
// steered to the right requester.
module ram_access_arbiter #(
  parameter int pRamAdrsWidth = 18,
  parameter int pRamDqWidth   = 16,
  parameter int pBurstMax     = 8,
  parameter int pTagDepth     = 8
) (
  input  logic                iCLK,
  input  logic                iRST,
  ram_access_arbiter_if.slave bus,
  output logic                oErr
);
  localparam int CW = $clog2(pBurstMax + 1);
  localparam int TW = $clog2(pTagDepth);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t                   state, stateNext;
  logic [CW-1:0]            burstCnt;
  logic                     lastB;      // last served side; reset favours A
  logic                     ackA, ackB, ack, burstLast;
  logic [pRamAdrsWidth-1:0] adrsSel;
  logic [pRamDqWidth-1:0]   wdSel;
  logic                     weSel;
  logic [pTagDepth-1:0]     tagMem;
  logic [TW-1:0]            wrPtr, rdPtr;
  logic [TW:0]              tagCnt;
  logic                     full, empty, push, pop;

  assign burstLast = (burstCnt == CW'(pBurstMax - 1));
  assign full      = (tagCnt == (TW+1)'(pTagDepth));
  assign empty     = (tagCnt == '0);

  // state register
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // next state
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (bus.iReqA && (!bus.iReqB || lastB)) stateNext = GNT_A;
        else if (bus.iReqB)                     stateNext = GNT_B;
      end
      GNT_A: begin
        if (!bus.iReqA)                             stateNext = bus.iReqB ? GNT_B : IDLE;
        else if (ackA && burstLast && bus.iReqB)    stateNext = GNT_B;
      end
      GNT_B: begin
        if (!bus.iReqB)                             stateNext = bus.iReqA ? GNT_A : IDLE;
        else if (ackB && burstLast && bus.iReqA)    stateNext = GNT_A;
      end
      default: stateNext = IDLE;
    endcase
  end

  // outputs: a full tag FIFO only stalls reads; acks are held off in reset
  always_comb begin
    ackA = 1'b0;
    ackB = 1'b0;
    if (!iRST) begin
      ackA = (state == GNT_A) && bus.iReqA && (bus.iWeA || !full);
      ackB = (state == GNT_B) && bus.iReqB && (bus.iWeB || !full);
    end
  end

  assign bus.oAckA = ackA;
  assign bus.oAckB = ackB;
  assign ack       = ackA || ackB;
  assign adrsSel   = ackB ? bus.iAdrsB : bus.iAdrsA;
  assign wdSel     = ackB ? bus.iWdB   : bus.iWdA;
  assign weSel     = ackB ? bus.iWeB   : bus.iWeA;

  // burst counter and round-robin pointer; both settle whenever a grant ends
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      burstCnt <= '0;
      lastB    <= 1'b1;
    end else if (state != IDLE && stateNext != state) begin
      burstCnt <= '0;
      lastB    <= (state == GNT_B);
    end else if (ack) begin
      burstCnt <= burstLast ? '0 : burstCnt + CW'(1);
    end
  end

  // beat issue register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bus.oCke  <= 1'b0;
      bus.oCmd  <= 1'b0;
      bus.oAdrs <= '0;
      bus.oWd   <= '0;
    end else begin
      bus.oCke <= ack;
      if (ack) begin
        bus.oAdrs <= adrsSel;
        bus.oWd   <= wdSel;
        bus.oCmd  <= weSel;
      end
    end
  end

  // read-owner tag FIFO (tag 1 = B)
  assign push = ack && !weSel;
  assign pop  = bus.iRvd && !empty;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      tagCnt <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + TW'(1);
      if (pop)  rdPtr <= rdPtr + TW'(1);
      case ({push, pop})
        2'b10:   tagCnt <= tagCnt + (TW+1)'(1);
        2'b01:   tagCnt <= tagCnt - (TW+1)'(1);
        default: tagCnt <= tagCnt;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) tagMem[wrPtr] <= ackB;
  end

  // read return; data with nothing outstanding is dropped and flagged
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bus.oRvdA <= 1'b0;
      bus.oRvdB <= 1'b0;
      bus.oRdA  <= '0;
      bus.oRdB  <= '0;
      oErr      <= 1'b0;
    end else begin
      bus.oRvdA <= pop && !tagMem[rdPtr];
      bus.oRvdB <= pop &&  tagMem[rdPtr];
      if (pop) begin
        bus.oRdA <= bus.iRd;
        bus.oRdB <= bus.iRd;
      end
      if (bus.iRvd && empty) oErr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_access_arbiter.sv
module tb_ram_access_arbiter;
  logic iCLK = 1'b0;
  logic iRST;
  logic oErr;
  int   checks = 0;
  int   failures = 0;

  ram_access_arbiter_if #(.pRamAdrsWidth(18), .pRamDqWidth(16)) bus ();

  ram_access_arbiter #(
    .pRamAdrsWidth(18), .pRamDqWidth(16), .pBurstMax(8), .pTagDepth(8)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .bus(bus.slave), .oErr(oErr)
  );

  always #5 iCLK = ~iCLK;

  task automatic cyc();
    @(posedge iCLK); #1;
  endtask

  task automatic smp();
    @(negedge iCLK);
  endtask

  task automatic idleInputs();
    bus.iReqA = 0; bus.iWeA = 0; bus.iAdrsA = '0; bus.iWdA = '0;
    bus.iReqB = 0; bus.iWeB = 0; bus.iAdrsB = '0; bus.iWdB = '0;
    bus.iRd = '0; bus.iRvd = 0;
  endtask

  task automatic apply_reset();
    idleInputs();
    iRST = 1; cyc(); cyc();
    iRST = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    iRST = 1; bus.iReqA = 1; bus.iWeA = 1;
    cyc(); cyc(); smp();
    checks++;
    if (bus.oAckA !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", bus.oAckA); end
    checks++;
    if ({bus.oCke, bus.oCmd, bus.oAdrs, bus.oWd} !== 36'h0) begin
      failures++; $display("FAIL rst_issue got=%h exp=0", {bus.oCke, bus.oCmd, bus.oAdrs, bus.oWd});
    end
    checks++;
    if ({bus.oRvdA, bus.oRvdB, bus.oRdA, bus.oRdB, oErr} !== 35'h0) begin
      failures++; $display("FAIL rst_return got=%h exp=0", {bus.oRvdA, bus.oRvdB, bus.oRdA, bus.oRdB, oErr});
    end
    iRST = 0;
  endtask

  task automatic test_writes_a();
    logic [35:0] exp;
    apply_reset();
    cyc(); bus.iReqA = 1; bus.iWeA = 1; bus.iAdrsA = 18'h10; bus.iWdA = 16'hA0;
    smp();
    checks++;
    if ({bus.oAckA, bus.oCke} !== 2'b00) begin failures++; $display("FAIL wr_idle got=%b exp=00", {bus.oAckA, bus.oCke}); end
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.iAdrsA = 18'(32'h10 + i); bus.iWdA = 16'(32'hA0 + i);
      smp();
      checks++;
      if (bus.oAckA !== 1'b1) begin failures++; $display("FAIL wr_ack[%0d] got=%b exp=1", i, bus.oAckA); end
      if (i > 0) begin
        exp = {1'b1, 1'b1, 18'(32'h10 + i - 1), 16'(32'hA0 + i - 1)};
        checks++;
        if ({bus.oCke, bus.oCmd, bus.oAdrs, bus.oWd} !== exp) begin
          failures++; $display("FAIL wr_issue[%0d] got=%h exp=%h", i, {bus.oCke, bus.oCmd, bus.oAdrs, bus.oWd}, exp);
        end
      end
    end
    cyc(); bus.iReqA = 0;
    smp();
    checks++;
    if ({bus.oAckA, bus.oCke, bus.oCmd, bus.oAdrs, bus.oWd} !== {1'b0, 1'b1, 1'b1, 18'h12, 16'hA2}) begin
      failures++; $display("FAIL wr_issue_last got=%h", {bus.oAckA, bus.oCke, bus.oCmd, bus.oAdrs, bus.oWd});
    end
    cyc(); smp();
    checks++;
    if ({bus.oCke, bus.oAdrs} !== {1'b0, 18'h12}) begin
      failures++; $display("FAIL wr_hold got=%h exp=%h", {bus.oCke, bus.oAdrs}, {1'b0, 18'h12});
    end
  endtask

  task automatic test_burst_solo();
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      cyc();
      if (k == 0) begin bus.iReqA = 1; bus.iWeA = 1; bus.iAdrsA = 18'h77; end
      smp();
      checks++;
      if (bus.oAckA !== (k != 0)) begin failures++; $display("FAIL solo_ack[%0d] got=%b exp=%b", k, bus.oAckA, k != 0); end
    end
    bus.iReqA = 0;
  endtask

  task automatic test_alternate();
    logic expA, expB, prevA;
    apply_reset();
    for (int k = 0; k <= 24; k++) begin
      cyc();
      if (k == 0) begin
        bus.iReqA = 1; bus.iWeA = 1; bus.iAdrsA = 18'h100; bus.iWdA = 16'h1;
        bus.iReqB = 1; bus.iWeB = 1; bus.iAdrsB = 18'h200; bus.iWdB = 16'h2;
      end
      smp();
      expA = (k >= 1) && (((k - 1) / 8) % 2 == 0);
      expB = (k >= 1) && (((k - 1) / 8) % 2 == 1);
      checks++;
      if ({bus.oAckA, bus.oAckB} !== {expA, expB}) begin
        failures++; $display("FAIL alt_ack[%0d] got=%b exp=%b", k, {bus.oAckA, bus.oAckB}, {expA, expB});
      end
      if (k >= 2) begin
        prevA = (((k - 2) / 8) % 2 == 0);
        checks++;
        if ({bus.oCke, bus.oAdrs} !== {1'b1, prevA ? 18'h100 : 18'h200}) begin
          failures++; $display("FAIL alt_issue[%0d] got=%h exp=%h", k, {bus.oCke, bus.oAdrs}, {1'b1, prevA ? 18'h100 : 18'h200});
        end
      end
    end
    bus.iReqA = 0; bus.iReqB = 0;
  endtask

  task automatic test_read_return();
    apply_reset();
    cyc(); bus.iReqA = 1; bus.iWeA = 0; bus.iAdrsA = 18'h20; bus.iReqB = 1; bus.iWeB = 0; bus.iAdrsB = 18'h30;
    smp();
    cyc(); smp();
    checks++;
    if ({bus.oAckA, bus.oAckB} !== 2'b10) begin failures++; $display("FAIL rd_ackA got=%b exp=10", {bus.oAckA, bus.oAckB}); end
    cyc(); bus.iReqA = 0; smp();
    checks++;
    if ({bus.oCke, bus.oCmd, bus.oAdrs} !== {1'b1, 1'b0, 18'h20}) begin
      failures++; $display("FAIL rd_issueA got=%h", {bus.oCke, bus.oCmd, bus.oAdrs});
    end
    cyc(); smp();
    checks++;
    if ({bus.oAckA, bus.oAckB} !== 2'b01) begin failures++; $display("FAIL rd_ackB got=%b exp=01", {bus.oAckA, bus.oAckB}); end
    cyc(); bus.iReqB = 0; smp();
    checks++;
    if ({bus.oCke, bus.oCmd, bus.oAdrs} !== {1'b1, 1'b0, 18'h30}) begin
      failures++; $display("FAIL rd_issueB got=%h", {bus.oCke, bus.oCmd, bus.oAdrs});
    end
    cyc(); bus.iRvd = 1; bus.iRd = 16'h1111; smp();
    cyc(); bus.iRd = 16'h2222; smp();
    checks++;
    if ({bus.oRvdA, bus.oRvdB, bus.oRdA} !== {1'b1, 1'b0, 16'h1111}) begin
      failures++; $display("FAIL rd_retA got=%h exp=%h", {bus.oRvdA, bus.oRvdB, bus.oRdA}, {1'b1, 1'b0, 16'h1111});
    end
    cyc(); bus.iRvd = 0; smp();
    checks++;
    if ({bus.oRvdA, bus.oRvdB, bus.oRdB} !== {1'b0, 1'b1, 16'h2222}) begin
      failures++; $display("FAIL rd_retB got=%h exp=%h", {bus.oRvdA, bus.oRvdB, bus.oRdB}, {1'b0, 1'b1, 16'h2222});
    end
    cyc(); smp();
    checks++;
    if ({bus.oRvdA, bus.oRvdB, oErr} !== 3'b000) begin
      failures++; $display("FAIL rd_quiet got=%b exp=000", {bus.oRvdA, bus.oRvdB, oErr});
    end
  endtask

  task automatic test_tag_full();
    logic expA, expB;
    apply_reset();
    for (int k = 0; k <= 14; k++) begin
      cyc();
      case (k)
        0: begin
          bus.iReqA = 1; bus.iWeA = 0; bus.iAdrsA = 18'h40;
          bus.iReqB = 1; bus.iWeB = 1; bus.iAdrsB = 18'h300; bus.iWdB = 16'hBEEF;
        end
        10: bus.iReqB = 0;
        12: begin bus.iRvd = 1; bus.iRd = 16'h5555; end
        13: bus.iRvd = 0;
        14: bus.iReqA = 0;
        default: ;
      endcase
      smp();
      expA = (k >= 1 && k <= 8) || k == 13;
      expB = (k == 9);
      checks++;
      if ({bus.oAckA, bus.oAckB} !== {expA, expB}) begin
        failures++; $display("FAIL full_ack[%0d] got=%b exp=%b", k, {bus.oAckA, bus.oAckB}, {expA, expB});
      end
      if (k == 13) begin
        checks++;
        if ({bus.oRvdA, bus.oRdA} !== {1'b1, 16'h5555}) begin
          failures++; $display("FAIL full_ret got=%h exp=%h", {bus.oRvdA, bus.oRdA}, {1'b1, 16'h5555});
        end
      end
      if (k == 14) begin
        checks++;
        if ({bus.oCke, bus.oCmd, bus.oAdrs} !== {1'b1, 1'b0, 18'h40}) begin
          failures++; $display("FAIL full_issue9 got=%h", {bus.oCke, bus.oCmd, bus.oAdrs});
        end
      end
    end
  endtask

  task automatic test_err();
    apply_reset();
    cyc(); bus.iRvd = 1; bus.iRd = 16'h7777;
    cyc(); bus.iRvd = 0; smp();
    checks++;
    if ({oErr, bus.oRvdA, bus.oRvdB} !== 3'b100) begin
      failures++; $display("FAIL err_set got=%b exp=100", {oErr, bus.oRvdA, bus.oRvdB});
    end
    cyc(); cyc(); cyc(); smp();
    checks++;
    if (oErr !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", oErr); end
    cyc(); iRST = 1;
    cyc(); iRST = 0; smp();
    checks++;
    if (oErr !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", oErr); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cyc(); bus.iReqA = 1; bus.iWeA = 0; bus.iAdrsA = 18'h50; smp();
    for (int k = 1; k <= 3; k++) begin
      cyc(); smp();
      checks++;
      if (bus.oAckA !== 1'b1) begin failures++; $display("FAIL mid_ack[%0d] got=%b exp=1", k, bus.oAckA); end
    end
    cyc(); iRST = 1; smp();
    checks++;
    if (bus.oAckA !== 1'b0) begin failures++; $display("FAIL mid_rst_ack got=%b exp=0", bus.oAckA); end
    cyc(); iRST = 0; smp();
    checks++;
    if ({bus.oCke, bus.oAckA} !== 2'b00) begin
      failures++; $display("FAIL mid_after_rst got=%b exp=00", {bus.oCke, bus.oAckA});
    end
    cyc(); smp();
    checks++;
    if (bus.oAckA !== 1'b1) begin failures++; $display("FAIL mid_post_ack got=%b exp=1", bus.oAckA); end
    cyc(); bus.iReqA = 0; smp();
    checks++;
    if ({bus.oCke, bus.oCmd, bus.oAdrs} !== {1'b1, 1'b0, 18'h50}) begin
      failures++; $display("FAIL mid_post_issue got=%h", {bus.oCke, bus.oCmd, bus.oAdrs});
    end
    // exactly one read outstanding now: the first return is valid, a second one is an error
    cyc(); bus.iRvd = 1; bus.iRd = 16'hABCD;
    cyc(); smp();
    checks++;
    if ({bus.oRvdA, bus.oRdA, oErr} !== {1'b1, 16'hABCD, 1'b0}) begin
      failures++; $display("FAIL mid_ret got=%h exp=%h", {bus.oRvdA, bus.oRdA, oErr}, {1'b1, 16'hABCD, 1'b0});
    end
    cyc(); bus.iRvd = 0; smp();
    checks++;
    if ({oErr, bus.oRvdA} !== 2'b10) begin
      failures++; $display("FAIL mid_fifo_empty got=%b exp=10", {oErr, bus.oRvdA});
    end
  endtask

  initial begin
    idleInputs();
    iRST = 1;
    test_reset();
    test_writes_a();
    test_burst_solo();
    test_alternate();
    test_read_return();
    test_tag_full();
    test_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
